// File: rtl/jt12_dac_serial_if.sv
// rtl/jt12_dac_serial_if.sv - sample input and serial DAC pin bundle for jt12_dac_serial
interface jt12_dac_serial_if;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample;
  logic        so;
  logic        bclk;
  logic        sh1;
  logic        sh2;
  logic        busy;
  logic        overrun;

  modport master (
    output left, right, sample,
    input  so, bclk, sh1, sh2, busy, overrun
  );

  modport slave (
    input  left, right, sample,
    output so, bclk, sh1, sh2, busy, overrun
  );
endinterface

// File: rtl/jt12_dac_serial.sv
// rtl/jt12_dac_serial.sv - 16-bit stereo samples to serial 3e/10m float words for YM3012-style DACs
module jt12_dac_serial #(
  parameter int DIV = 2,
  parameter int WIN = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  jt12_dac_serial_if.slave dac
);

  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(DIV / 2);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  tick_cnt, tick_nxt;
  logic [4:0]     bit_cnt, bit_nxt;
  logic [WIN-1:0] cur_l, cur_r, pend_l, pend_r;
  logic           pend_v, pend_v_nxt;
  logic           ovr, ovr_nxt;
  logic           load_in, load_pend, store_pend;
  logic [15:0]    word_l, word_r;
  logic           busy_i;

  // Exponent picks the smallest shift that keeps the sign bit inside the 10-bit mantissa.
  function automatic logic [15:0] to_float(input logic [15:0] x);
    logic [3:0]  p;
    logic [2:0]  e;
    logic [15:0] sh;
    p = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (x[i] != x[15]) p = 4'(i);
    end
    e  = (p > 4'd8) ? 3'(p - 4'd7) : 3'd1;
    sh = x >> (e - 3'd1);
    return {e, sh[9:0], 3'b000};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      pend_v   <= 1'b0;
      ovr      <= 1'b0;
      cur_l    <= '0;
      cur_r    <= '0;
      pend_l   <= '0;
      pend_r   <= '0;
    end else if (clk_en) begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      pend_v   <= pend_v_nxt;
      ovr      <= ovr_nxt;
      if (load_in) begin
        cur_l <= dac.left;
        cur_r <= dac.right;
      end else if (load_pend) begin
        cur_l <= pend_l;
        cur_r <= pend_r;
      end
      if (store_pend) begin
        pend_l <= dac.left;
        pend_r <= dac.right;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    bit_nxt    = bit_cnt;
    pend_v_nxt = pend_v;
    ovr_nxt    = 1'b0;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    case (state)
      IDLE: begin
        if (dac.sample) begin
          state_nxt = SEND;
          tick_nxt  = '0;
          bit_nxt   = '0;
          load_in   = 1'b1;
        end
      end
      SEND: begin
        ovr_nxt = dac.sample & pend_v;
        if (tick_cnt == TICK_LAST) begin
          tick_nxt = '0;
          bit_nxt  = bit_cnt + 5'd1;
        end else begin
          tick_nxt = tick_cnt + TW'(1);
        end
        // A strobe on the frame's final tick is handed straight to the next frame.
        if (bit_cnt == 5'd31 && tick_cnt == TICK_LAST) begin
          pend_v_nxt = 1'b0;
          if (dac.sample)  load_in   = 1'b1;
          else if (pend_v) load_pend = 1'b1;
          else             state_nxt = IDLE;
        end else if (dac.sample) begin
          store_pend = 1'b1;
          pend_v_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign word_l      = to_float(cur_l);
  assign word_r      = to_float(cur_r);
  assign busy_i      = (state == SEND);
  assign dac.busy    = busy_i;
  assign dac.so      = busy_i & (bit_cnt[4] ? word_r[bit_cnt[3:0]] : word_l[bit_cnt[3:0]]);
  assign dac.bclk    = busy_i & (tick_cnt < TICK_HALF);
  assign dac.sh1     = busy_i & ~bit_cnt[4];
  assign dac.sh2     = busy_i & bit_cnt[4];
  assign dac.overrun = ovr;

endmodule

// File: tb/tb_jt12_dac_serial.sv
// tb/tb_jt12_dac_serial.sv - bench for jt12_dac_serial at DIV=2 and DIV=4
module tb_jt12_dac_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        sample = 1'b0;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  int          checks = 0;
  int          errors = 0;
  bit          cmp_on = 1'b0;

  always #5 clk = ~clk;

  jt12_dac_serial_if bus_a ();
  jt12_dac_serial_if bus_b ();

  assign bus_a.left = left;
  assign bus_a.right = right;
  assign bus_a.sample = sample;
  assign bus_b.left = left;
  assign bus_b.right = right;
  assign bus_b.sample = sample;

  jt12_dac_serial #(.DIV(2), .WIN(16)) dut_a (.clk(clk), .rst(rst), .clk_en(clk_en), .dac(bus_a));
  jt12_dac_serial #(.DIV(4), .WIN(16)) dut_b (.clk(clk), .rst(rst), .clk_en(clk_en), .dac(bus_b));

  wire [5:0] obs_a = {bus_a.so, bus_a.bclk, bus_a.sh1, bus_a.sh2, bus_a.busy, bus_a.overrun};
  wire [5:0] obs_b = {bus_b.so, bus_b.bclk, bus_b.sh1, bus_b.sh2, bus_b.busy, bus_b.overrun};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a frame is 32*div ticks; output is a pure function of the tick position.
  int          divs [2] = '{2, 4};
  bit          m_act [2];
  bit          m_pv [2];
  bit          m_ovr [2];
  int          m_pos [2];
  logic [31:0] m_frame [2];
  logic [31:0] m_pend [2];

  function automatic logic [15:0] conv_model(input logic [15:0] x);
    int          v, s;
    logic [15:0] w;
    bit          done;
    v = int'($signed(x));
    w = '0;
    done = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      s = v >>> (e - 1);
      if (!done && s >= -512 && s <= 511) begin
        w = {3'(e), 10'(s), 3'b000};
        done = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [5:0] model_outs(input int n);
    int b, ph;
    logic [5:0] o;
    o = '0;
    if (m_act[n]) begin
      b = m_pos[n] / divs[n];
      ph = m_pos[n] % divs[n];
      o[5] = m_frame[n][b];
      o[4] = (ph < divs[n] / 2);
      o[3] = (b < 16);
      o[2] = (b >= 16);
      o[1] = 1'b1;
    end
    o[0] = m_ovr[n];
    return o;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        m_act[n] = 0; m_pv[n] = 0; m_ovr[n] = 0; m_pos[n] = 0;
      end else if (clk_en) begin
        m_ovr[n] = 0;
        if (!m_act[n]) begin
          if (sample) begin
            m_act[n] = 1; m_pos[n] = 0;
            m_frame[n] = {conv_model(right), conv_model(left)};
          end
        end else begin
          if (sample) begin
            m_ovr[n] = m_pv[n];
            m_pend[n] = {conv_model(right), conv_model(left)};
            m_pv[n] = 1;
          end
          if (m_pos[n] == 32 * divs[n] - 1) begin
            if (m_pv[n]) begin
              m_frame[n] = m_pend[n]; m_pv[n] = 0; m_pos[n] = 0;
            end else begin
              m_act[n] = 0;
            end
          end else begin
            m_pos[n]++;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("model_a", obs_a, model_outs(0));
      chk("model_b", obs_b, model_outs(1));
    end
  end

  task automatic step(input bit en, input bit stb, input logic [15:0] l, input logic [15:0] r, input bit rs);
    clk_en = en; sample = stb; left = l; right = r; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((bus_a.busy || bus_b.busy) && k < 400) begin
      step(1, 0, 16'h0, 16'h0, 0);
      k++;
    end
    chk("drain", {31'b0, bus_a.busy | bus_b.busy}, 0);
  endtask

  task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input string tag,
                           input logic [15:0] exp_l, input logic [15:0] exp_r);
    logic [31:0] w;
    int busy_n, s1f, s1l, s2f, s2l;
    w = '0; busy_n = 0; s1f = -1; s1l = -1; s2f = -1; s2l = -1;
    step(1, 1, l, r, 0);
    for (int t = 1; t <= 70; t++) begin
      if (bus_a.busy) busy_n++;
      if (bus_a.sh1) begin if (s1f < 0) s1f = t; s1l = t; end
      if (bus_a.sh2) begin if (s2f < 0) s2f = t; s2l = t; end
      if (t <= 64 && t % 2 == 1) w[(t - 1) / 2] = bus_a.so;
      step(1, 0, l, r, 0);
    end
    chk({tag, "_left_word"}, w[15:0], exp_l);
    chk({tag, "_right_word"}, w[31:16], exp_r);
    chk({tag, "_busy_ticks"}, busy_n, 64);
    chk({tag, "_sh1_first"}, s1f, 1);
    chk({tag, "_sh1_last"}, s1l, 32);
    chk({tag, "_sh2_first"}, s2f, 33);
    chk({tag, "_sh2_last"}, s2l, 64);
    drain();
  endtask

  // Strobes at tick 0 (left=0), t2 and optionally t3; checks the second frame's left word.
  task automatic burst(input string tag, input int t2, input logic [15:0] l2, input int t3,
                       input logic [15:0] l3, input logic [15:0] exp_w, input int exp_ovr_n,
                       input int exp_ovr_edge);
    logic [15:0] w;
    int ovr_n, ovr_edge, gap;
    bit stb;
    logic [15:0] l;
    w = '0; ovr_n = 0; ovr_edge = -1; gap = 0;
    for (int t = 0; t <= 140; t++) begin
      if (t >= 1) begin
        if (bus_a.overrun) begin ovr_n++; ovr_edge = t - 1; end
        if (t <= 128 && !bus_a.busy) gap++;
        if (t >= 65 && t <= 95 && (t - 65) % 2 == 0) w[(t - 65) / 2] = bus_a.so;
      end
      stb = (t == 0) || (t == t2) || (t == t3);
      l = (t == t2) ? l2 : (t == t3) ? l3 : 16'h0000;
      step(1, stb, l, 16'h0000, 0);
    end
    chk({tag, "_frame2_left"}, w, exp_w);
    chk({tag, "_overrun_count"}, ovr_n, exp_ovr_n);
    chk({tag, "_overrun_edge"}, ovr_edge, exp_ovr_edge);
    chk({tag, "_idle_gap"}, gap, 0);
    drain();
  endtask

  initial begin
    logic [5:0]  snap_a, snap_b;
    logic [15:0] wb;
    logic [7:0]  pat;
    int          busy_n;

    chk("conv_0100", conv_model(16'h0100), 16'h2800);
    chk("conv_8000", conv_model(16'h8000), 16'hF000);
    chk("conv_7FFF", conv_model(16'h7FFF), 16'hEFF8);
    chk("conv_0400", conv_model(16'h0400), 16'h6800);
    chk("conv_FFFF", conv_model(16'hFFFF), 16'h3FF8);
    chk("conv_0005", conv_model(16'h0005), 16'h2028);

    step(1, 0, 16'h0, 16'h0, 1);
    cmp_on = 1'b1;
    step(1, 1, 16'h1111, 16'h2222, 1);
    step(1, 0, 16'h0, 16'h0, 1);
    chk("reset_outs_a", obs_a, 6'b0);
    chk("reset_outs_b", obs_b, 6'b0);
    rst = 1'b0;

    run_frame(16'h0100, 16'h8000, "t1", 16'h2800, 16'hF000);
    run_frame(16'h7FFF, 16'h0400, "t2", 16'hEFF8, 16'h6800);

    burst("t3", 20, 16'h0003, 30, 16'h0005, 16'h2028, 1, 30);
    burst("last_tick", 63, 16'h0040, -1, 16'h0000, 16'h2200, 0, -1);

    step(1, 1, 16'h1234, 16'h5678, 0);
    for (int t = 1; t <= 9; t++) step(1, 0, 16'h0, 16'h0, 0);
    step(1, 1, 16'h4000, 16'h4000, 1);
    chk("rst_outs_a", obs_a, 6'b0);
    chk("rst_outs_b", obs_b, 6'b0);
    step(1, 0, 16'h0, 16'h0, 0);
    chk("strobe_with_rst", {31'b0, bus_a.busy}, 0);
    step(1, 1, 16'h0100, 16'h8000, 0);
    chk("fresh_frame_a", obs_a, 6'b011010);
    drain();

    step(0, 1, 16'h1234, 16'h5678, 0);
    chk("strobe_en_low", {31'b0, bus_a.busy | bus_b.busy}, 0);
    step(1, 1, 16'h1234, 16'hABCD, 0);
    busy_n = 1;
    for (int t = 1; t <= 5; t++) begin
      step(1, 0, 16'h0, 16'h0, 0);
      if (bus_a.busy) busy_n++;
    end
    snap_a = obs_a;
    snap_b = obs_b;
    for (int t = 0; t < 5; t++) begin
      step(0, 0, 16'h0, 16'h0, 0);
      chk("hold_a", obs_a, snap_a);
      chk("hold_b", obs_b, snap_b);
    end
    for (int t = 0; t < 200 && bus_a.busy; t++) begin
      step(1, 0, 16'h0, 16'h0, 0);
      if (bus_a.busy) busy_n++;
    end
    chk("stall_busy_ticks", busy_n, 64);
    drain();

    step(1, 1, 16'hFFFF, 16'h0000, 0);
    busy_n = 0; wb = '0; pat = '0;
    for (int t = 1; t <= 140; t++) begin
      if (bus_b.busy) busy_n++;
      if (t <= 8) pat[t - 1] = bus_b.bclk;
      if (t <= 61 && (t - 1) % 4 == 0) wb[(t - 1) / 4] = bus_b.so;
      step(1, 0, 16'h0, 16'h0, 0);
    end
    chk("div4_busy_ticks", busy_n, 128);
    chk("div4_bclk_pattern", pat, 8'h33);
    chk("div4_left_word", wb, 16'h3FF8);
    drain();

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
